// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 round-engine definitions: byte count, round
//               FSM state encoding, GF(2^8) doubling and the column-major
//               byte addressing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // State bytes are stored column-major: byte index = column*4 + row.
  function automatic int unsigned byte_pos(input int unsigned row, input int unsigned col);
    return col * 4 + row;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_col.sv
`default_nettype none
// ============================================================================
// Module      : mix_col
// Description : AES MixColumns for a single column (matrix 2 3 1 1 circulant).
// Ports       : din  [0:31] in  - column, row 0 in din[0 +: 8]
//               dout [0:31] out - mixed column, same order
// Revision    : 1.0 - initial release
// ============================================================================
module mix_col (
  input  logic [0:31] din,
  output logic [0:31] dout
);
  import aes_pkg::*;

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = din[0  +: 8];
  assign w_a1 = din[8  +: 8];
  assign w_a2 = din[16 +: 8];
  assign w_a3 = din[24 +: 8];

  // 3*b is expressed as xtime(b) ^ b.
  assign dout[0  +: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
  assign dout[8  +: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
  assign dout[16 +: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
  assign dout[24 +: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);

endmodule
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// ============================================================================
// Module      : sbox
// Description : AES forward S-box. Computes the multiplicative inverse in
//               GF(2^8) as b^254 with a square-and-multiply chain, followed
//               by the AES affine transform. 0 maps through inverse 0.
// Ports       : din  [7:0] in  - input byte
//               dout [7:0] out - substituted byte
// Revision    : 1.0 - initial release
// ============================================================================
module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  import aes_pkg::*;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240;
  logic [7:0] w_x252, w_inv;

  // Exponent chain: 2,3,6,12,15,30,60,120,240,252,254
  assign w_x2   = gf_mul(din, din);
  assign w_x3   = gf_mul(w_x2, din);
  assign w_x6   = gf_mul(w_x3, w_x3);
  assign w_x12  = gf_mul(w_x6, w_x6);
  assign w_x15  = gf_mul(w_x12, w_x3);
  assign w_x30  = gf_mul(w_x15, w_x15);
  assign w_x60  = gf_mul(w_x30, w_x30);
  assign w_x120 = gf_mul(w_x60, w_x60);
  assign w_x240 = gf_mul(w_x120, w_x120);
  assign w_x252 = gf_mul(w_x240, w_x12);
  assign w_inv  = gf_mul(w_x252, w_x2);

  assign dout = w_inv
              ^ {w_inv[6:0], w_inv[7]}
              ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]}
              ^ {w_inv[3:0], w_inv[7:4]}
              ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/shift_rows.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows
// Description : AES ShiftRows. Row r is rotated left by r columns.
// Ports       : din  [0:127] in  - state, byte k = din[8k +: 8]
//               dout [0:127] out - shifted state, same byte order
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rows (
  input  logic [0:127] din,
  output logic [0:127] dout
);
  import aes_pkg::*;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign dout[8*byte_pos(r, c) +: 8] = din[8*byte_pos(r, (c + r) % 4) +: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_seq
// Description : Sequential AES-128 encryption round. SubBytes is applied
//               SBOX_LANES bytes per cycle, then ShiftRows, MixColumns
//               (skipped on the final round) and AddRoundKey finish the
//               round in one cycle. The result is held until accepted.
// Parameters  : SBOX_LANES - S-boxes instantiated (1, 2, 4, 8 or 16)
// Ports       : clk         in  - clock, rising edge
//               rst_n       in  - synchronous active-low reset
//               in_valid    in  - round request present
//               in_ready    out - engine can accept a request
//               state_in    in  [0:127] - input state, byte k at [8k +: 8]
//               round_key   in  [0:127] - round key, same order
//               final_round in  - 1 skips MixColumns
//               out_valid   out - result valid
//               out_ready   in  - consumer accepts the result
//               state_out   out [0:127] - round result
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_seq #(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] state_in,
  input  logic [0:127] round_key,
  input  logic         final_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] state_out
);
  import aes_pkg::*;

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
        SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
    $error("aes_round_seq: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] c_lanes = 5'(SBOX_LANES);
  localparam logic [4:0] c_bytes = 5'(AES_BYTES);

  state_t       r_state;
  logic [0:127] r_work;
  logic [0:127] r_key;
  logic         r_final;
  logic [4:0]   r_byte_idx;
  logic         r_out_valid;
  logic [0:127] r_state_out;

  logic         w_accept;
  logic [3:0]   w_lane_idx [SBOX_LANES];
  logic [7:0]   w_sub_in   [SBOX_LANES];
  logic [7:0]   w_sub_out  [SBOX_LANES];
  logic [0:127] w_shifted;
  logic [0:127] w_mixed;
  logic [0:127] w_round;

  // Ready in DONE only when the result leaves this cycle, so a new request
  // can overlap the handoff.
  assign in_ready  = rst_n && ((r_state == IDLE) || (r_state == DONE && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign state_out = r_state_out;

  // The lane index wraps at 4 bits; byte_idx reaches 16 only after the last
  // SUB cycle, when the selected bytes are no longer used.
  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
    assign w_lane_idx[l] = r_byte_idx[3:0] + 4'(l);
    assign w_sub_in[l]   = r_work[{w_lane_idx[l], 3'b000} +: 8];
    sbox u_sbox (
      .din  (w_sub_in[l]),
      .dout (w_sub_out[l])
    );
  end

  shift_rows u_shift_rows (
    .din  (r_work),
    .dout (w_shifted)
  );

  for (genvar c = 0; c < 4; c++) begin : g_mix
    mix_col u_mix_col (
      .din  (w_shifted[32*c +: 32]),
      .dout (w_mixed[32*c +: 32])
    );
  end

  assign w_round = (r_final ? w_shifted : w_mixed) ^ r_key;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_key       <= '0;
      r_final     <= 1'b0;
      r_byte_idx  <= '0;
      r_out_valid <= 1'b0;
      r_state_out <= '0;
    end else begin
      case (r_state)
        SUB: begin
          for (int l = 0; l < SBOX_LANES; l++) begin
            r_work[{w_lane_idx[l], 3'b000} +: 8] <= w_sub_out[l];
          end
          r_byte_idx <= r_byte_idx + c_lanes;
          if (r_byte_idx + c_lanes == c_bytes) r_state <= MIX;
        end
        MIX: begin
          r_state_out <= w_round;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: ;
      endcase

      // Accept overrides the DONE->IDLE step above when both happen together.
      if (w_accept) begin
        r_work     <= state_in;
        r_key      <= round_key;
        r_final    <= final_round;
        r_byte_idx <= '0;
        r_state    <= SUB;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_seq
// Description : Self-checking bench for aes_round_seq. One instance per legal
//               SBOX_LANES value shares the inputs; the SBOX_LANES=4 instance
//               is the main subject. Results are checked against FIPS-197
//               vectors and a byte-array AES round model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_seq;

  localparam int NDUT = 5;
  localparam int M    = 2;   // instance with SBOX_LANES = 4

  localparam logic [0:127] R1_IN    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [0:127] R1_KEY   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] R1_OUT   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [0:127] R10_IN   = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [0:127] R10_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:127] R10_OUT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] ZERO_OUT = {16{8'h63}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         final_round;
  logic         out_ready;
  logic [0:127] state_in;
  logic [0:127] round_key;
  logic         rdy  [NDUT];
  logic         vld  [NDUT];
  logic [0:127] sout [NDUT];

  int checks   = 0;
  int failures = 0;
  logic [7:0] sbox_tbl [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    aes_round_seq #(.SBOX_LANES(1 << g)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (rdy[g]),
      .state_in    (state_in),
      .round_key   (round_key),
      .final_round (final_round),
      .out_valid   (vld[g]),
      .out_ready   (out_ready),
      .state_out   (sout[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Standard S-box table built by walking generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tbl[0] = 8'h63;
  endtask

  function automatic int gmul(input int a, input int n);
    int r, x;
    r = 0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (((n >> i) & 1) != 0) r = r ^ x;
      x = x * 2;
      if (x > 255) x = x ^ 'h11B;
    end
    return r;
  endfunction

  function automatic logic [0:127] ref_round(input logic [0:127] st, input logic [0:127] key,
                                             input bit fin);
    int s [4][4];
    int t [4][4];
    int a [4];
    logic [0:127] res;
    for (int k = 0; k < 16; k++) s[k % 4][k / 4] = int'(sbox_tbl[st[8*k +: 8]]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = s[r][(c + r) % 4];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) a[r] = t[r][c];
        for (int r = 0; r < 4; r++)
          t[r][c] = gmul(a[r], 2) ^ gmul(a[(r + 1) % 4], 3) ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
      end
    end
    for (int k = 0; k < 16; k++) res[8*k +: 8] = 8'(t[k % 4][k / 4]) ^ key[8*k +: 8];
    return res;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request, wait (bounded) for the main instance to be ready,
  // and let it be accepted on the next edge.
  task automatic accept(input logic [0:127] st, input logic [0:127] key, input bit fin);
    int n;
    state_in    = st;
    round_key   = key;
    final_round = fin;
    in_valid    = 1'b1;
    #1;
    n = 0;
    while (!rdy[M] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk_int("accept_timeout", n, 0);
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid of the main instance; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      if (vld[M]) lat = c;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int lats [NDUT];
    int seen;
    logic [0:127] st, key, exp;
    bit fin;

    build_sbox();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    final_round = 1'b0;
    state_in    = '0;
    round_key   = '0;
    tick();
    tick();

    // Reset state
    chk_int("reset_out_valid", int'(vld[M]), 0);
    chk("reset_state_out", sout[M], '0);
    chk_int("reset_in_ready", int'(rdy[M]), 0);
    rst_n = 1'b1;
    #1;
    chk_int("idle_in_ready", int'(rdy[M]), 1);

    // FIPS-197 round 1 on every lane count in parallel
    accept(R1_IN, R1_KEY, 1'b0);
    for (int d = 0; d < NDUT; d++) lats[d] = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int d = 0; d < NDUT; d++) if (vld[d] && lats[d] < 0) lats[d] = c;
    end
    for (int d = 0; d < NDUT; d++) begin
      chk_int($sformatf("r1_latency_lanes%0d", 1 << d), lats[d], (16 >> d) + 1);
      chk($sformatf("r1_out_lanes%0d", 1 << d), sout[d], R1_OUT);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_int("release_out_valid", int'(vld[M]), 0);
    chk_int("release_in_ready", int'(rdy[M]), 1);

    // Zero round
    accept('0, '0, 1'b0);
    wait_out(lat);
    chk_int("zero_latency", lat, 5);
    chk("zero_out", sout[M], ZERO_OUT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Final round (no MixColumns)
    accept(R10_IN, R10_KEY, 1'b1);
    wait_out(lat);
    chk_int("r10_latency", lat, 5);
    chk("r10_out", sout[M], R10_OUT);
    chk("r10_model", ref_round(R10_IN, R10_KEY, 1'b1), sout[M]);

    // Backpressure on the held round-10 result
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_int("bp_out_valid", int'(vld[M]), 1);
      chk("bp_state_out", sout[M], R10_OUT);
      chk_int("bp_in_ready", int'(rdy[M]), 0);
    end
    out_ready = 1'b1;
    #1;
    chk_int("bp_handoff_ready", int'(rdy[M]), 1);
    accept(R1_IN, R1_KEY, 1'b0);
    out_ready = 1'b0;
    chk_int("bp_after_handoff_valid", int'(vld[M]), 0);
    wait_out(lat);
    chk_int("bp_next_latency", lat, 5);
    chk("bp_next_out", sout[M], R1_OUT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Inputs changing during SUB must not affect the round
    accept(R1_IN, R1_KEY, 1'b0);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      state_in    = rand128();
      round_key   = rand128();
      final_round = ~final_round;
      tick();
      if (vld[M]) lat = c;
    end
    chk_int("hold_latency", lat, 5);
    chk("hold_out", sout[M], R1_OUT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of SUB
    accept(rand128(), rand128(), 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk_int("midrst_out_valid", int'(vld[M]), 0);
    chk("midrst_state_out", sout[M], '0);
    rst_n = 1'b1;
    #1;
    chk_int("midrst_in_ready", int'(rdy[M]), 1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (vld[M]) seen++;
    end
    chk_int("midrst_no_valid", seen, 0);
    accept(R1_IN, R1_KEY, 1'b0);
    wait_out(lat);
    chk_int("midrst_fresh_latency", lat, 5);
    chk("midrst_fresh_out", sout[M], R1_OUT);

    // Randomized rounds, alternating idle gaps and overlapped handoffs
    for (int i = 0; i < 16; i++) begin
      st  = rand128();
      key = rand128();
      fin = 1'($urandom_range(0, 1));
      exp = ref_round(st, key, fin);
      out_ready = 1'b1;
      if (i % 2 == 0) begin
        tick();
        out_ready = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      accept(st, key, fin);
      out_ready = 1'b0;
      wait_out(lat);
      chk_int("rand_latency", lat, 5);
      chk("rand_out", sout[M], exp);
      repeat ($urandom_range(0, 3)) tick();
      chk("rand_out_held", sout[M], exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_int("final_out_valid", int'(vld[M]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_round_seq.md
# aes_round_seq

Sequential, parametrised AES-128 encryption round engine, successor to the purely combinational round datapath. It accepts a 128-bit state and round key over a valid/ready handshake. SubBytes runs over `SBOX_LANES` bytes per cycle, then ShiftRows, optional MixColumns and AddRoundKey complete the round, and the result is held until the consumer accepts it. It sits between a future round-sequencing controller / key schedule and the state register, trading area (S-box count) for latency.

## Interface
- `SBOX_LANES`, default 4: S-boxes instantiated; legal values 1, 2, 4, 8, 16. Any other value is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset. Synchronous, active-low.
- `in_valid` in 1: a round request is present.
- `in_ready` out 1: the engine can accept a request.
- `state_in` in [0:127]: input state. Byte k = `state_in[8k +: 8]`; AES column-major, row k%4, column k/4.
- `round_key` in [0:127]: round key, same byte order.
- `final_round` in 1: 1 skips MixColumns (AES round 10).
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `state_out` out [0:127]: round result, same byte order.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. Leaves on accept.
  - SUB: byte substitution.
  - MIX: finish the round.
  - DONE: `out_valid`=1.
- Accept (`in_valid && in_ready`):
  - Latch `state_in`, `round_key` and `final_round` into internal registers.
  - Clear `byte_idx` (5 bits).
  - Go to SUB.
- SUB, each cycle:
  - Bytes `byte_idx .. byte_idx+SBOX_LANES-1` of the working register are replaced by their S-box output.
  - `byte_idx += SBOX_LANES`.
  - When `byte_idx + SBOX_LANES == 16`, go to MIX. SUB lasts exactly 16/SBOX_LANES cycles.
- MIX (one cycle):
  - Compute `state_out <= MixColumns(ShiftRows(work)) ^ key`, or `ShiftRows(work) ^ key` when the latched `final_round`=1.
  - Go to DONE.
- DONE:
  - Hold `out_valid`=1 and a stable `state_out` until `out_ready`.
  - On `out_ready`: if `in_valid` in the same cycle, accept the new request and go to SUB; otherwise go to IDLE.
- `in_ready` = IDLE, or (DONE and `out_ready`). It is combinational from the FSM state and `out_ready`. It is 0 while `rst_n`=0.
- Inputs are sampled only at accept; changes to `state_in`, `round_key` or `final_round` at any other time have no effect.
- Arithmetic:
  - MixColumns over GF(2^8) with polynomial 0x11B.
  - `xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00)`.
  - All operations are byte-wise; no carries.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - FSM→IDLE, `byte_idx`=0, `out_valid`=0, `state_out`=128'h0.
  - Internal state/key/final_round registers are cleared.
  - Reset mid-SUB, MIX or DONE aborts the round; no `out_valid` follows.
- Latency: accept at edge 0, `out_valid` rises after edge 16/SBOX_LANES + 1. Cycle counts per `SBOX_LANES`:
  - 16 → 2 cycles
  - 4 → 5 cycles
  - 1 → 17 cycles
- Throughput with `out_ready` held high: one round per 16/SBOX_LANES + 2 cycles (the DONE cycle overlaps the next accept).
- `out_valid` never drops without `out_ready`=1 in the same cycle; `state_out` is constant while `out_valid`=1.
- `out_ready` while not in DONE is ignored.

## Structure
- Shared package `aes_pkg`:
  - `AES_BYTES`=16.
  - FSM state enum (IDLE/SUB/MIX/DONE).
  - `xtime` function.
  - Byte-index helper for column-major addressing.
- Reuse the existing `sbox` module, instantiated `SBOX_LANES` times in a generate loop, fed by a byte-select mux on `byte_idx`.
- Reuse the existing `shift_rows` and `mix_col` modules combinationally in MIX. The `final_round` bypass and key XOR are local.
- No other sub-modules.

## Test plan
- **Zero round:** reset, then `state_in`=0, `round_key`=0, `final_round`=0 → `state_out`=`63636363…63` (all 16 bytes 0x63). `out_valid` appears exactly 5 cycles after accept (`SBOX_LANES`=4).
- **FIPS-197 App. B round 1:**
  - `state_in`=`193de3bea0f4e22b9ac68d2ae9f84808`
  - `round_key`=`a0fafe1788542cb123a339392a6c7605`
  - `final_round`=0
  - → `state_out`=`a49c7ff2689f352b6b5bea43026a5049`
  - Repeat for `SBOX_LANES` = 1, 2, 4, 8, 16; latency 17 / 9 / 5 / 3 / 2.
- **FIPS-197 round 10:**
  - `state_in`=`eb40f21e592e38848ba113e71bc342d2`
  - `round_key`=`d014f9a8c9ee2589e13f0cc8b6630ca6`
  - `final_round`=1
  - → `state_out`=`3925841d02dc09fbdc118597196a0b32`
- **Backpressure:** hold `out_ready`=0 for 10 cycles → `out_valid` and `state_out` stable and `in_ready`=0 throughout. Raise `out_ready` together with `in_valid` and a new request → accepted that cycle; the next result follows 5 cycles later.
- **Input hold:** change `state_in` and `round_key` during SUB → result unchanged (round-1 vector still matches).
- **Reset mid-round:** pulse `rst_n`=0 during SUB → next cycle `out_valid`=0, `state_out`=0, `in_ready`=1. A fresh request then completes correctly.
